cpu_checker_param: RTL and testbench
====================================

Name: cpu_checker_param

Overview:
- Parametrised, streaming checker for CPU trace lines. Consumes one ASCII character per clock.
- Recognises register-write lines: ^<time>@<pc>: $<grf> <= <data>#
- Recognises memory-write lines: ^<time>@<pc>: *<addr> <= <data>#
- Reports format and semantic errors, with configurable legal ranges, alignment checks and running line/error counters.
- Sits in the pre-Verilog trace tooling between the character source and the scoreboard/log collector.

Parameters:
- TIME_DIGITS, 4, max decimal digits of time (1..TIME_DIGITS accepted).
- GRF_DIGITS, 4, max decimal digits of grf (1..GRF_DIGITS accepted).
- NUM_REGS, 32, grf legal iff value < NUM_REGS.
- PC_MIN, 32'h3000, lowest legal pc.
- PC_MAX, 32'h4fff, highest legal pc.
- ADDR_MIN, 32'h0, lowest legal addr.
- ADDR_MAX, 32'h2fff, highest legal addr.
- ALIGN_CHECK, 1, 1 = pc and addr must be word-aligned (bits[1:0]==0).
- CNT_W, 16, width of line counters.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- char  input  8  ASCII character, sampled every rising edge
- freq  input  16  power of two, >=2; time must be a multiple of freq/2
- valid  output  1  one-cycle pulse, line accepted
- format_type  output  2  01 = register line, 10 = memory line, 00 when valid=0
- error_code  output  4  error bits, 0 when valid=0
- line_cnt  output  CNT_W  count of accepted lines
- err_line_cnt  output  CNT_W  count of accepted lines with error_code != 0

Behaviour:
- Reset (reset=0, asynchronous): all outputs and counters 0, FSM to S_IDLE, accumulators cleared.
- Character classes:
  - dec = '0'..'9'
  - hex = dec or 'a'..'f' (lowercase only)
  - sp = ' '
- '^' in any state (including S_DONE) goes to S_CARET and clears all accumulators. This is the restart rule.
- Any character not listed for the current state, and not '^', goes to S_IDLE.
- States and transitions:
  - S_IDLE: '^' -> S_CARET.
  - S_CARET: dec -> S_TIME.
  - S_TIME: dec while digit count < TIME_DIGITS stays; '@' -> S_PC_FIRST.
  - S_PC_FIRST: hex -> S_PC.
  - S_PC: hex while hex count < 8 stays; ':' only when exactly 8 hex digits seen -> S_SP1.
  - S_SP1: sp stays; '$' -> S_DOLLAR; '*' -> S_STAR.
  - S_DOLLAR: dec -> S_GRF.
  - S_GRF: dec while count < GRF_DIGITS stays; sp -> S_SP2; '<' -> S_LT.
  - S_STAR: hex -> S_ADDR.
  - S_ADDR: hex while count < 8 stays; sp or '<' only when exactly 8 seen -> S_SP2 or S_LT respectively.
  - S_SP2: sp stays; '<' -> S_LT.
  - S_LT: '=' -> S_EQ.
  - S_EQ: sp stays; hex -> S_DATA.
  - S_DATA: hex while count < 8 stays; '#' only when exactly 8 seen -> S_DONE.
  - S_DONE: '^' -> S_CARET, else -> S_IDLE.
- Accumulation:
  - time = time*10 + digit (TIME_DIGITS*4 bits).
  - grf = grf*10 + digit.
  - pc and addr shift left 4 and OR in the nibble, 32 bits.
  - One shared digit counter, cleared on every state change.
- Error bits, evaluated from the fully accumulated values at S_DONE entry:
  - [0]: (time & ((freq>>1)-1)) != 0.
  - [1]: pc < PC_MIN, or pc > PC_MAX, or (ALIGN_CHECK and pc[1:0]!=0).
  - [2]: memory line and (addr < ADDR_MIN, or addr > ADDR_MAX, or (ALIGN_CHECK and addr[1:0]!=0)); always 0 on register lines.
  - [3]: register line and grf >= NUM_REGS; always 0 on memory lines.
- Outputs are registered. valid, format_type and error_code are non-zero only in the single cycle the FSM is in S_DONE.
  - Latency: 1 cycle after the edge that samples '#'.
- Counters update on the same edge that enters S_DONE:
  - line_cnt += 1.
  - err_line_cnt += 1 if the computed error is non-zero.
  - Both wrap modulo 2^CNT_W.
- Boundary cases:
  - Too many digits in time or grf (beyond TIME_DIGITS / GRF_DIGITS) -> S_IDLE.
  - 9th hex digit -> S_IDLE.
  - Terminator after fewer than 8 hex digits -> S_IDLE.
  - freq changing mid-line: the value sampled on the '#' edge is used.
  - Reset mid-line: the line is discarded, nothing counted.

Decomposition:
- Package cpu_checker_pkg holds:
  - state encoding localparams;
  - FMT_REG=2'b01, FMT_MEM=2'b10;
  - error-bit indices ERR_TIME=0, ERR_PC=1, ERR_ADDR=2, ERR_GRF=3;
  - ASCII constants for ^ @ : $ * < = # and space.
- One combinational sub-module, cpu_checker_char_class: char -> is_dec, is_hex, nibble[3:0].
- FSM, accumulators, checks and counters stay in the top module.

Test Plan (defaults, freq=4):
- "^10@00003010: $5 <= 1234abcd#" -> one cycle later: valid=1, format_type=01, error_code=0000; line_cnt=1, err_line_cnt=0.
- "^11@00003010: *00000010 <=0000ffff#" -> valid=1, format_type=10, error_code=0001 (11 is odd); err_line_cnt=1.
- "^8@00002ffe: $40<=00000001#" -> valid=1, format_type=01, error_code=1010 (pc below range and misaligned; grf 40 >= 32).
- "^12@0000301: $1<=00000000#" (7 pc digits) followed by "^^4@00003000: *00003000 <= 00000000#":
  - first line -> no valid pulse;
  - second line -> valid=1, format_type=10, error_code=0100;
  - line_cnt increments by exactly 1.
- reset=0 asserted for 1 cycle after "^10@00003000: $3" -> all outputs and counters 0 immediately. Next full legal line -> valid=1, error_code=0000, line_cnt=1.
- Back-to-back lines "...#^20@00003004: $0<=00000000#" with '^' directly after '#' -> two valid pulses, line_cnt=2. The second line's time=20 with freq=64 -> error_code=0001.

Source files
------------

// File: rtl/cpu_checker_pkg.sv
// Shared encodings for the CPU trace-line checker: FSM states, line formats,
// error-bit positions and the ASCII punctuation the grammar is built from.
package cpu_checker_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_CARET    = 4'd1;
    localparam state_t S_TIME     = 4'd2;
    localparam state_t S_PC_FIRST = 4'd3;
    localparam state_t S_PC       = 4'd4;
    localparam state_t S_SP1      = 4'd5;
    localparam state_t S_DOLLAR   = 4'd6;
    localparam state_t S_GRF      = 4'd7;
    localparam state_t S_STAR     = 4'd8;
    localparam state_t S_ADDR     = 4'd9;
    localparam state_t S_SP2      = 4'd10;
    localparam state_t S_LT       = 4'd11;
    localparam state_t S_EQ       = 4'd12;
    localparam state_t S_DATA     = 4'd13;
    localparam state_t S_DONE     = 4'd14;

    localparam logic [1:0] FMT_REG = 2'b01;
    localparam logic [1:0] FMT_MEM = 2'b10;

    localparam int ERR_TIME = 0;
    localparam int ERR_PC   = 1;
    localparam int ERR_ADDR = 2;
    localparam int ERR_GRF  = 3;

    localparam logic [7:0] CH_CARET  = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SP     = 8'h20;

    // Bounds arrive as arguments so a zero lower bound is not a constant compare.
    function automatic logic in_range(input logic [31:0] v,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/cpu_checker_char_class.sv
// Character classifier: decimal digit, lowercase hex digit and its nibble value.
module cpu_checker_char_class (
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nibble
);

    always_comb begin
        is_dec = (char >= 8'h30) && (char <= 8'h39);
        is_hex = is_dec || ((char >= 8'h61) && (char <= 8'h66));
        nibble = 4'd0;
        if (is_dec)
            nibble = char[3:0];
        else if (is_hex)
            nibble = char[3:0] + 4'd9;
    end

endmodule

// File: rtl/cpu_checker_param.sv
// Streaming checker for CPU trace lines (register and memory writes), one
// character per clock, with range/alignment checks and line/error counters.
module cpu_checker_param
    import cpu_checker_pkg::*;
#(
    parameter int          TIME_DIGITS = 4,
    parameter int          GRF_DIGITS  = 4,
    parameter int          NUM_REGS    = 32,
    parameter logic [31:0] PC_MIN      = 32'h3000,
    parameter logic [31:0] PC_MAX      = 32'h4fff,
    parameter logic [31:0] ADDR_MIN    = 32'h0,
    parameter logic [31:0] ADDR_MAX    = 32'h2fff,
    parameter int          ALIGN_CHECK = 1,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic [15:0]      freq,
    output logic             valid,
    output logic [1:0]       format_type,
    output logic [3:0]       error_code,
    output logic [CNT_W-1:0] line_cnt,
    output logic [CNT_W-1:0] err_line_cnt
);

    localparam int TW = TIME_DIGITS * 4;
    localparam int GW = GRF_DIGITS * 4;

    logic          is_dec, is_hex;
    logic [3:0]    nibble;
    state_t        state_q, state_nx;
    logic [7:0]    cnt_q;
    logic [TW-1:0] time_acc;
    logic [GW-1:0] grf_acc;
    logic [31:0]   pc_acc, addr_acc;
    logic          is_mem;
    logic [1:0]    fmt_q;
    logic [3:0]    err_q, err_nx;
    logic [31:0]   time_mask;

    cpu_checker_char_class u_class (
        .char   (char),
        .is_dec (is_dec),
        .is_hex (is_hex),
        .nibble (nibble)
    );

    always_comb begin
        state_nx = S_IDLE;
        if (char == CH_CARET) begin
            state_nx = S_CARET;
        end else begin
            case (state_q)
                S_CARET:    if (is_dec) state_nx = S_TIME;
                S_TIME:     if (is_dec && cnt_q < 8'(TIME_DIGITS)) state_nx = S_TIME;
                            else if (char == CH_AT) state_nx = S_PC_FIRST;
                S_PC_FIRST: if (is_hex) state_nx = S_PC;
                S_PC:       if (is_hex && cnt_q < 8'd8) state_nx = S_PC;
                            else if (char == CH_COLON && cnt_q == 8'd8) state_nx = S_SP1;
                S_SP1:      if (char == CH_SP) state_nx = S_SP1;
                            else if (char == CH_DOLLAR) state_nx = S_DOLLAR;
                            else if (char == CH_STAR) state_nx = S_STAR;
                S_DOLLAR:   if (is_dec) state_nx = S_GRF;
                S_GRF:      if (is_dec && cnt_q < 8'(GRF_DIGITS)) state_nx = S_GRF;
                            else if (char == CH_SP) state_nx = S_SP2;
                            else if (char == CH_LT) state_nx = S_LT;
                S_STAR:     if (is_hex) state_nx = S_ADDR;
                S_ADDR:     if (is_hex && cnt_q < 8'd8) state_nx = S_ADDR;
                            else if (char == CH_SP && cnt_q == 8'd8) state_nx = S_SP2;
                            else if (char == CH_LT && cnt_q == 8'd8) state_nx = S_LT;
                S_SP2:      if (char == CH_SP) state_nx = S_SP2;
                            else if (char == CH_LT) state_nx = S_LT;
                S_LT:       if (char == CH_EQ) state_nx = S_EQ;
                S_EQ:       if (char == CH_SP) state_nx = S_EQ;
                            else if (is_hex) state_nx = S_DATA;
                S_DATA:     if (is_hex && cnt_q < 8'd8) state_nx = S_DATA;
                            else if (char == CH_HASH && cnt_q == 8'd8) state_nx = S_DONE;
                default:    state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        time_mask        = (32'(freq) >> 1) - 32'd1;
        err_nx           = 4'd0;
        err_nx[ERR_TIME] = (32'(time_acc) & time_mask) != 32'd0;
        err_nx[ERR_PC]   = !in_range(pc_acc, PC_MIN, PC_MAX) ||
                           ((ALIGN_CHECK != 0) && (pc_acc[1:0] != 2'b00));
        err_nx[ERR_ADDR] = is_mem && (!in_range(addr_acc, ADDR_MIN, ADDR_MAX) ||
                           ((ALIGN_CHECK != 0) && (addr_acc[1:0] != 2'b00)));
        err_nx[ERR_GRF]  = !is_mem && (32'(grf_acc) >= 32'(NUM_REGS));
    end

    // The digit that causes entry into a digit state is already the first one counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            time_acc     <= '0;
            grf_acc      <= '0;
            pc_acc       <= 32'd0;
            addr_acc     <= 32'd0;
            is_mem       <= 1'b0;
            fmt_q        <= 2'b00;
            err_q        <= 4'd0;
            line_cnt     <= '0;
            err_line_cnt <= '0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= (state_nx == state_q) ? cnt_q + 8'd1 : 8'd1;
            if (char == CH_CARET) begin
                time_acc <= '0;
                grf_acc  <= '0;
                pc_acc   <= 32'd0;
                addr_acc <= 32'd0;
                is_mem   <= 1'b0;
            end else begin
                case (state_nx)
                    S_TIME:  time_acc <= time_acc * TW'(10) + TW'(nibble);
                    S_GRF:   grf_acc  <= grf_acc * GW'(10) + GW'(nibble);
                    S_PC:    pc_acc   <= {pc_acc[27:0], nibble};
                    S_ADDR:  addr_acc <= {addr_acc[27:0], nibble};
                    S_STAR:  is_mem   <= 1'b1;
                    default: ;
                endcase
            end
            if (state_nx == S_DONE) begin
                fmt_q        <= is_mem ? FMT_MEM : FMT_REG;
                err_q        <= err_nx;
                line_cnt     <= line_cnt + CNT_W'(1);
                err_line_cnt <= err_line_cnt + CNT_W'(err_nx != 4'd0);
            end
        end
    end

    always_comb begin
        valid       = (state_q == S_DONE);
        format_type = valid ? fmt_q : 2'b00;
        error_code  = valid ? err_q : 4'd0;
    end

endmodule

// File: tb/tb_cpu_checker_param.sv
// Scoreboard bench for cpu_checker_param: expected pulses queued as lines are
// driven, popped and compared when the checker reports a line.
module tb_cpu_checker_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char;
    logic [15:0] freq;
    logic        valid;
    logic [1:0]  format_type;
    logic [3:0]  error_code;
    logic [15:0] line_cnt;
    logic [15:0] err_line_cnt;

    typedef struct {
        logic [1:0]  fmt;
        logic [3:0]  err;
        logic [15:0] lc;
        logic [15:0] ec;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_lc = 16'd0;
    logic [15:0] model_ec = 16'd0;

    cpu_checker_param dut (
        .clk          (clk),
        .reset        (reset),
        .char         (char),
        .freq         (freq),
        .valid        (valid),
        .format_type  (format_type),
        .error_code   (error_code),
        .line_cnt     (line_cnt),
        .err_line_cnt (err_line_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] c);
        char = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) put(s[i]);
    endtask

    task automatic push_exp(input logic [1:0] fmt, input logic [3:0] err);
        exp_t e;
        model_lc = model_lc + 16'd1;
        if (err != 4'd0) model_ec = model_ec + 16'd1;
        e.fmt = fmt;
        e.err = err;
        e.lc  = model_lc;
        e.ec  = model_ec;
        sb.push_back(e);
    endtask

    task automatic send_line(input string s, input logic [1:0] fmt, input logic [3:0] err);
        push_exp(fmt, err);
        send_str(s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(8'h00);
    endtask

    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_valid", {31'b0, valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("format_type", {30'b0, format_type}, {30'b0, e.fmt});
                check_eq("error_code", {28'b0, error_code}, {28'b0, e.err});
                check_eq("line_cnt", {16'b0, line_cnt}, {16'b0, e.lc});
                check_eq("err_line_cnt", {16'b0, err_line_cnt}, {16'b0, e.ec});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        char  = 8'h00;
        freq  = 16'd4;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", {31'b0, valid}, 32'd0);
        check_eq("rst_fmt", {30'b0, format_type}, 32'd0);
        check_eq("rst_err", {28'b0, error_code}, 32'd0);
        check_eq("rst_line_cnt", {16'b0, line_cnt}, 32'd0);
        check_eq("rst_err_line_cnt", {16'b0, err_line_cnt}, 32'd0);
        reset = 1'b1;
        idle(2);

        send_line("^10@00003010: $5 <= 1234abcd#", 2'b01, 4'b0000);
        send_line("^11@00003010: *00000010 <=0000ffff#", 2'b10, 4'b0001);
        send_line("^8@00002ffe: $40<=00000001#", 2'b01, 4'b1010);
        send_str("^12@0000301: $1<=00000000#");
        send_line("^^4@00003000: *00003000 <= 00000000#", 2'b10, 4'b0100);

        send_str("^12345@00003000: $1<=00000000#");
        send_str("^4@000030000: $1<=00000000#");
        send_str("^4@00003000: $12345<=00000000#");
        send_str("^4@00003000: $1<=0000000#");
        send_str("^4@00003000: *0000300<=00000000#");
        send_line("^9996@00003000: $31<=00000000#", 2'b01, 4'b0000);
        send_line("^4@00005000: *00002ffc<=00000000#", 2'b10, 4'b0010);
        idle(3);

        send_str("^10@00003000: $3");
        reset = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'b0, valid}, 32'd0);
        check_eq("mid_rst_fmt", {30'b0, format_type}, 32'd0);
        check_eq("mid_rst_err", {28'b0, error_code}, 32'd0);
        check_eq("mid_rst_line_cnt", {16'b0, line_cnt}, 32'd0);
        check_eq("mid_rst_err_line_cnt", {16'b0, err_line_cnt}, 32'd0);
        model_lc = 16'd0;
        model_ec = 16'd0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_line("^10@00003000: $3<=00000000#", 2'b01, 4'b0000);

        freq = 16'd64;
        send_line("^32@00003000: $1<=00000000#", 2'b01, 4'b0000);
        send_line("^20@00003004: $0<=00000000#", 2'b01, 4'b0001);

        push_exp(2'b01, 4'b0000);
        send_str("^2@00003000: $1<=0000000");
        freq = 16'd4;
        send_str("0#");
        idle(4);

        check_eq("sb_drained", sb.size(), 32'd0);
        check_eq("final_line_cnt", {16'b0, line_cnt}, {16'b0, model_lc});
        check_eq("final_err_line_cnt", {16'b0, err_line_cnt}, {16'b0, model_ec});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
